// File: rtl/move_sequencer.sv
// Move sequencer: owns the 4x4 board, streams four lines per move through a shared
// merge unit, spawns new tiles and evaluates win / game-over.
module move_sequencer #(
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int unsigned WIN_EXP = 11
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic [3:0]  dir,
   output logic        merge_req,
   output logic [15:0] merge_line,
   input  logic        merge_ack,
   input  logic [15:0] merge_result,
   output logic [63:0] board,
   output logic        busy,
   output logic        won,
   output logic        game_over,
   output logic [2:0]  state
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] REQ   = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] SPAWN = 3'd4;
   localparam logic [2:0] CHECK = 3'd5;
   localparam logic [2:0] OVER  = 3'd6;
   localparam logic [2:0] CLEAR = 3'd7;

   logic [2:0]  r_state, w_state_nxt;
   logic [63:0] r_board, w_board_nxt;
   logic [15:0] r_line, w_line_nxt;
   logic [15:0] r_res, w_res_nxt;
   logic [15:0] r_lfsr;
   logic [3:0]  r_dir_prev;
   logic [3:0]  r_dir, w_dir_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic        r_changed, w_changed_nxt;
   logic [1:0]  r_cnt, w_cnt_nxt;
   logic [3:0]  r_ptr, w_ptr_nxt;
   logic [3:0]  r_probe, w_probe_nxt;
   logic        r_won, w_won_nxt;

   logic [3:0]  w_tile [16];
   logic        w_full, w_pair, w_any_win, w_accept;
   logic [3:0]  w_spawn_val;

   // Board cell (4r+c) holding element e of line i for the latched direction.
   function automatic logic [3:0] cell_of(input logic [3:0] d, input logic [1:0] i,
                                          input logic [1:0] e);
      logic [1:0] r, c;
      if (d[3]) begin
         r = e;         c = i;
      end else if (d[2]) begin
         r = 2'd3 - e;  c = i;
      end else if (d[0]) begin
         r = i;         c = 2'd3 - e;
      end else begin
         r = i;         c = e;
      end
      return {r, c};
   endfunction

   always_comb begin
      w_full    = 1'b1;
      w_pair    = 1'b0;
      w_any_win = 1'b0;
      for (int p = 0; p < 16; p++) begin
         w_tile[p] = r_board[63-4*p -: 4];
         if (w_tile[p] == 4'd0) w_full = 1'b0;
         if (32'(w_tile[p]) >= WIN_EXP) w_any_win = 1'b1;
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (w_tile[4*r+c] != 4'd0 && w_tile[4*r+c] == w_tile[4*r+c+1]) w_pair = 1'b1;
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (w_tile[4*r+c] != 4'd0 && w_tile[4*r+c] == w_tile[4*r+c+4]) w_pair = 1'b1;
         end
      end
   end

   assign w_accept    = (r_dir_prev == 4'd0) && (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
   assign w_spawn_val = (r_lfsr[15:12] == 4'd0) ? 4'd2 : 4'd1;

   always_comb begin
      w_state_nxt   = r_state;
      w_board_nxt   = r_board;
      w_line_nxt    = r_line;
      w_res_nxt     = r_res;
      w_dir_nxt     = r_dir;
      w_idx_nxt     = r_idx;
      w_changed_nxt = r_changed;
      w_cnt_nxt     = r_cnt;
      w_ptr_nxt     = r_ptr;
      w_probe_nxt   = r_probe;
      w_won_nxt     = r_won;
      if (start) begin
         w_state_nxt = CLEAR;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_dir_nxt     = dir;
                  w_idx_nxt     = 2'd0;
                  w_changed_nxt = 1'b0;
                  w_state_nxt   = LOAD;
               end
            end
            LOAD: begin
               for (int e = 0; e < 4; e++) begin
                  w_line_nxt[15-4*e -: 4] = w_tile[cell_of(r_dir, r_idx, 2'(e))];
               end
               w_state_nxt = REQ;
            end
            REQ: begin
               if (merge_ack) begin
                  w_res_nxt   = merge_result;
                  w_state_nxt = WRITE;
               end
            end
            WRITE: begin
               for (int e = 0; e < 4; e++) begin
                  w_board_nxt[63-4*int'(cell_of(r_dir, r_idx, 2'(e))) -: 4] = r_res[15-4*e -: 4];
               end
               w_changed_nxt = r_changed | (r_res != r_line);
               if (r_idx != 2'd3) begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_state_nxt = LOAD;
               end else if (w_changed_nxt) begin
                  w_cnt_nxt   = 2'd1;
                  w_ptr_nxt   = r_lfsr[3:0];
                  w_probe_nxt = 4'd0;
                  w_state_nxt = SPAWN;
               end else begin
                  w_state_nxt = CHECK;
               end
            end
            SPAWN: begin
               if (w_tile[r_ptr] == 4'd0) begin
                  w_board_nxt[63-4*int'(r_ptr) -: 4] = w_spawn_val;
                  w_cnt_nxt   = r_cnt - 2'd1;
                  w_ptr_nxt   = r_lfsr[3:0];
                  w_probe_nxt = 4'd0;
                  if (r_cnt == 2'd1) w_state_nxt = CHECK;
               end else if (r_probe == 4'd15) begin
                  w_state_nxt = CHECK;
               end else begin
                  w_ptr_nxt   = r_ptr + 4'd1;
                  w_probe_nxt = r_probe + 4'd1;
               end
            end
            CHECK: begin
               w_won_nxt   = r_won | w_any_win;
               w_state_nxt = (w_full && !w_pair) ? OVER : IDLE;
            end
            OVER: w_state_nxt = OVER;
            default: begin
               w_board_nxt = '0;
               w_won_nxt   = 1'b0;
               w_cnt_nxt   = 2'd2;
               w_ptr_nxt   = r_lfsr[3:0];
               w_probe_nxt = 4'd0;
               w_state_nxt = SPAWN;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_board    <= '0;
         r_line     <= '0;
         r_res      <= '0;
         r_lfsr     <= SEED;
         r_dir_prev <= '0;
         r_dir      <= '0;
         r_idx      <= '0;
         r_changed  <= 1'b0;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_probe    <= '0;
         r_won      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_board    <= w_board_nxt;
         r_line     <= w_line_nxt;
         r_res      <= w_res_nxt;
         r_lfsr     <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         r_dir_prev <= dir;
         r_dir      <= w_dir_nxt;
         r_idx      <= w_idx_nxt;
         r_changed  <= w_changed_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
         r_probe    <= w_probe_nxt;
         r_won      <= w_won_nxt;
      end
   end

   assign merge_req  = (r_state == REQ);
   assign merge_line = r_line;
   assign board      = r_board;
   assign busy       = (r_state != IDLE) && (r_state != OVER);
   assign won        = r_won;
   assign game_over  = (r_state == OVER);
   assign state      = r_state;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer; acts as the line-merge unit with scripted results.
module tb_move_sequencer;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [3:0]  dir;
   logic        merge_req;
   logic [15:0] merge_line;
   logic        merge_ack;
   logic [15:0] merge_result;
   logic [63:0] board;
   logic        busy, won, game_over;
   logic [2:0]  state;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] mv_res   [4];
   bit          mv_echo  [4];
   logic [15:0] mv_line  [4];
   int          mv_hi    [4];
   int          mv_delay_idx, mv_delay, mv_lat, mv_nreq, extra_req;
   bit          mv_stable, mv_hold;

   move_sequencer dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .dir         (dir),
      .merge_req   (merge_req),
      .merge_line  (merge_line),
      .merge_ack   (merge_ack),
      .merge_result(merge_result),
      .board       (board),
      .busy        (busy),
      .won         (won),
      .game_over   (game_over),
      .state       (state)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int count_tiles(input logic [63:0] b);
      int n = 0;
      for (int p = 0; p < 16; p++) if (b[63-4*p -: 4] != 4'd0) n++;
      return n;
   endfunction

   function automatic bit tiles_small(input logic [63:0] b);
      logic [3:0] t;
      for (int p = 0; p < 16; p++) begin
         t = b[63-4*p -: 4];
         if (t > 4'd2) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic wait_state(input logic [2:0] s, input string tag);
      for (int i = 0; i < 100 && state != s; i++) @(negedge clock);
      check_eq(tag, 64'(state), 64'(s));
   endtask

   // Pulses (or holds) dir and serves every merge request until IDLE/OVER.
   task automatic run_move(input logic [3:0] d);
      int  idx = 0;
      int  hi = 0;
      logic prev_req = 1'b0;
      mv_stable = 1'b1;
      mv_nreq = 0;
      mv_lat = -1;
      for (int k = 0; k < 4; k++) begin
         mv_line[k] = '0;
         mv_hi[k] = 0;
      end
      @(negedge clock);
      dir = d;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clock);
         if (cyc == 0 && !mv_hold) dir = 4'd0;
         merge_ack = 1'b0;
         if (state == 3'd0 || state == 3'd6) begin
            mv_lat = cyc;
            break;
         end
         if (merge_req && !prev_req) mv_nreq++;
         prev_req = merge_req;
         if (merge_req && idx < 4) begin
            if (hi == 0) mv_line[idx] = merge_line;
            else if (merge_line != mv_line[idx]) mv_stable = 1'b0;
            hi++;
            if (hi >= ((idx == mv_delay_idx) ? mv_delay : 1)) begin
               merge_ack    = 1'b1;
               merge_result = mv_echo[idx] ? mv_line[idx] : mv_res[idx];
               mv_hi[idx]   = hi;
               idx++;
               hi = 0;
            end
         end
      end
   endtask

   initial begin
      logic [3:0] n2, n3;
      resetn = 1'b0;
      start = 1'b0;
      dir = 4'd0;
      merge_ack = 1'b0;
      merge_result = '0;
      mv_delay_idx = -1;
      mv_delay = 1;
      mv_hold = 1'b0;
      mv_echo = '{0, 0, 0, 0};
      mv_res = '{16'h0, 16'h0, 16'h0, 16'h0};
      #12;
      check_eq("rst_board", board, 64'h0);
      check_eq("rst_req", 64'(merge_req), 64'h0);
      check_eq("rst_line", 64'(merge_line), 64'h0);
      check_eq("rst_flags", 64'({busy, won, game_over}), 64'h0);
      check_eq("rst_state", 64'(state), 64'h0);
      @(negedge clock);
      resetn = 1'b1;

      // New game: two tiles of value 1 or 2.
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_eq("start_clear", 64'(state), 64'd7);
      wait_state(3'd0, "start_idle");
      check_eq("start_tiles", 64'(count_tiles(board)), 64'd2);
      check_eq("start_vals", 64'(tiles_small(board)), 64'd1);
      check_eq("start_busy", 64'(busy), 64'd0);

      // M1 left: overwrite all rows, board becomes full; no spawn possible.
      mv_res = '{16'h1123, 16'h4545, 16'h5454, 16'h4545};
      run_move(4'b0010);
      check_eq("m1_board", board, 64'h1123_4545_5454_4545);
      check_eq("m1_lat", 64'(mv_lat), 64'd29);
      check_eq("m1_nreq", 64'(mv_nreq), 64'd4);

      // M2 left: row0 merges to 2,2,0,0; line 2 acked after 5 cycles.
      mv_res = '{16'h2200, 16'h0, 16'h0, 16'h0};
      mv_echo = '{0, 1, 1, 1};
      mv_delay_idx = 2;
      mv_delay = 5;
      run_move(4'b0010);
      mv_delay_idx = -1;
      check_eq("m2_line0", 64'(mv_line[0]), 64'h1123);
      check_eq("m2_line1", 64'(mv_line[1]), 64'h4545);
      check_eq("m2_line2", 64'(mv_line[2]), 64'h5454);
      check_eq("m2_line3", 64'(mv_line[3]), 64'h4545);
      check_eq("m2_nreq", 64'(mv_nreq), 64'd4);
      check_eq("m2_req_hi2", 64'(mv_hi[2]), 64'd5);
      check_eq("m2_req_hi0", 64'(mv_hi[0]), 64'd1);
      check_eq("m2_stable", 64'(mv_stable), 64'd1);
      check_eq("m2_rows123", 64'(board[47:0]), 64'h4545_5454_4545);
      check_eq("m2_row0_head", 64'(board[63:56]), 64'h22);
      n2 = board[55:52];
      n3 = board[51:48];
      check_eq("m2_one_spawn", 64'(int'(n2 != 0) + int'(n3 != 0)), 64'd1);
      check_eq("m2_spawn_val", 64'((n2 | n3) == 4'd1 || (n2 | n3) == 4'd2), 64'd1);
      check_eq("m2_state", 64'(state), 64'd0);

      // M3 up: column i becomes all (i+1).
      mv_echo = '{0, 0, 0, 0};
      mv_res = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      run_move(4'b1000);
      check_eq("m3_line0", 64'(mv_line[0]), 64'h2454);
      check_eq("m3_line1", 64'(mv_line[1]), 64'h2545);
      check_eq("m3_board", board, 64'h1234_1234_1234_1234);

      // Unmovable left / right with echoing merge unit: no spawn, 13 cycles.
      mv_echo = '{1, 1, 1, 1};
      run_move(4'b0010);
      check_eq("m4_line0", 64'(mv_line[0]), 64'h1234);
      check_eq("m4_lat", 64'(mv_lat), 64'd13);
      check_eq("m4_board", board, 64'h1234_1234_1234_1234);
      run_move(4'b0001);
      check_eq("m4r_line3", 64'(mv_line[3]), 64'h4321);
      check_eq("m4r_lat", 64'(mv_lat), 64'd13);
      check_eq("m4r_board", board, 64'h1234_1234_1234_1234);

      // Multi-bit dir is not a move.
      run_move(4'b0011);
      check_eq("multi_lat", 64'(mv_lat), 64'd0);
      check_eq("multi_nreq", 64'(mv_nreq), 64'd0);

      // Held dir yields exactly one move.
      mv_hold = 1'b1;
      run_move(4'b0010);
      extra_req = 0;
      repeat (20) begin
         @(negedge clock);
         if (merge_req) extra_req++;
      end
      check_eq("held_nreq", 64'(mv_nreq + extra_req), 64'd4);
      check_eq("held_state", 64'(state), 64'd0);
      dir = 4'd0;
      mv_hold = 1'b0;

      // M5 down: a tile of 11 appears.
      mv_echo = '{0, 0, 0, 0};
      mv_res = '{16'h111B, 16'h2221, 16'h3332, 16'h4443};
      run_move(4'b0100);
      check_eq("m5_line0", 64'(mv_line[0]), 64'h1111);
      check_eq("m5_board", board, 64'hB123_1234_1234_1234);
      check_eq("m5_won", 64'(won), 64'd1);
      check_eq("m5_state", 64'(state), 64'd0);

      // M6 down: full checkerboard, no equal neighbours -> OVER.
      mv_res = '{16'h2121, 16'h1212, 16'h2121, 16'h1212};
      run_move(4'b0100);
      check_eq("m6_board", board, 64'h1212_2121_1212_2121);
      check_eq("m6_lat", 64'(mv_lat), 64'd29);
      check_eq("m6_over", 64'({game_over, busy, state}), 64'({1'b1, 1'b0, 3'd6}));
      check_eq("m6_won_sticky", 64'(won), 64'd1);
      run_move(4'b0010);
      check_eq("over_ignores_dir", 64'(state), 64'd6);

      // New game from OVER, then start in the middle of a handshake.
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_eq("g2_clear", 64'(state), 64'd7);
      wait_state(3'd0, "g2_idle");
      check_eq("g2_tiles", 64'(count_tiles(board)), 64'd2);
      check_eq("g2_won", 64'({won, game_over}), 64'd0);
      @(negedge clock);
      dir = 4'b1000;
      @(negedge clock);
      dir = 4'd0;
      for (int i = 0; i < 10 && !merge_req; i++) @(negedge clock);
      check_eq("g2_in_req", 64'(merge_req), 64'd1);
      @(negedge clock);
      start = 1'b1;
      merge_ack = 1'b1;
      merge_result = 16'hFFFF;
      @(negedge clock);
      start = 1'b0;
      merge_ack = 1'b0;
      check_eq("abort_req", 64'(merge_req), 64'd0);
      check_eq("abort_state", 64'(state), 64'd7);
      @(negedge clock);
      check_eq("abort_board", board, 64'h0);
      check_eq("abort_spawn", 64'(state), 64'd4);
      wait_state(3'd0, "g3_idle");
      check_eq("g3_tiles", 64'(count_tiles(board)), 64'd2);
      check_eq("g3_vals", 64'(tiles_small(board)), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Owns the 16-tile board register and sequences one player move end to end.
- Per move: slices the board into four lines for the chosen direction, shares a single external line-merge unit across them over a req/ack handshake, and writes the results back.
- Then spawns one new tile into an empty cell, and evaluates win and game-over.
- Sits between the key/direction front end and draw_grid; board drives the renderer directly.

Parameters:
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- WIN_EXP, 11, tile exponent that raises won (11 = 2048).

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  level; a new game is requested while high.
- dir  in  4  one-hot direction: [3]=up, [2]=down, [1]=left, [0]=right.
- merge_req  out  1  line valid to the merge unit.
- merge_line  out  16  four 4-bit tiles; element 0 at [15:12] is the end tiles slide toward.
- merge_ack  in  1  merge result valid.
- merge_result  in  16  compacted/merged line, same packing as merge_line.
- board  out  64  tile exponents, row-major; cell(r,c) at [63-16r-4c -: 4]; 0 = empty.
- busy  out  1  high in any state other than IDLE or OVER.
- won  out  1  sticky, set when any tile ≥ WIN_EXP.
- game_over  out  1  high in OVER.
- state  out  3  FSM state code, for HEX debug.

Behaviour:
- Reset: board=0, merge_req=0, merge_line=0, busy=0, won=0, game_over=0, state=IDLE(0), lfsr=SEED, line index=0, dir history=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle.
- State codes: IDLE=0, LOAD=1, REQ=2, WRITE=3, SPAWN=4, CHECK=5, OVER=6, CLEAR=7.
- start:
  - High in any state, including mid-move or mid-handshake → CLEAR next cycle.
  - merge_req drops immediately and a pending ack is ignored.
  - CLEAR: board=0, won=0, spawn count=2 → SPAWN.
  - start has priority over dir.
- Move accept (IDLE only):
  - dir registered every cycle; accepted when the previous sample was 0 and the current value is exactly one-hot.
  - Multi-bit or held dir is ignored; dir is also ignored outside IDLE.
  - On accept: latch dir, line index=0, changed=0 → LOAD.
- LOAD: build merge_line for line index i:
  - left: row i, c=0..3.
  - right: row i, c=3..0.
  - up: column i, r=0..3.
  - down: column i, r=3..0.
  - Then → REQ.
- REQ:
  - merge_req=1, merge_line held stable until merge_ack is sampled high.
  - On that edge, capture merge_result and → WRITE.
  - merge_req is low in WRITE.
  - No timeout.
- WRITE:
  - Scatter the result back in the same element order.
  - changed |= (result != line).
  - i<3 → i+1, LOAD; i==3 → SPAWN with count=1 if changed, else → CHECK.
- Minimum move latency, ack in the first REQ cycle: 4×(LOAD+REQ+WRITE) = 12 cycles to SPAWN.
- SPAWN:
  - Scan pointer initialised from lfsr[3:0]; tests one cell per cycle, wrapping 15→0.
  - First empty cell gets exponent 2 if lfsr[15:12]==0, else 1.
  - Decrement count; count 0 → CHECK, else rescan.
  - No empty cell after 16 probes → CHECK without writing.
- CHECK (one cycle):
  - won |= any tile ≥ WIN_EXP.
  - If no empty cell and no horizontally or vertically adjacent equal nonzero pair → OVER, else → IDLE.
- OVER: game_over=1; exits only via start.
- Widths: tiles are not incremented here; merge_result is trusted as-is, with no saturation.

Test Plan:
- Reset then start pulse → after CLEAR/SPAWN/CHECK: exactly two cells nonzero, each 1 or 2; busy=0; state=0.
- Preload via start + forced board row0={1,1,2,0}, dir=left, merge unit returns {2,2,0,0} → row0 = 2,2,0,0; one new tile in a previously empty cell; merge_req toggles exactly 4 times.
- Board that cannot move left, dir=left, merge unit echoes input → no tile spawned, board unchanged, back to IDLE after 13 cycles.
- merge_ack delayed 5 cycles on line 2 → merge_line stable throughout, merge_req high for exactly 5 cycles, result written correctly.
- dir=4'b0011, and dir held high across two moves → no move accepted / exactly one move.
- Full board, no equal neighbours → game_over=1, state=6. Then start mid-REQ of the next game → merge_req=0 next cycle, board cleared, then reseeded.
- Merge returns tile 11 → won=1, and it stays 1 until start.
